i2c_slave_regfile: RTL and testbench

Parametrised I2C target with an internal byte register file, a register pointer, and multi-byte burst read/write.
- Pointer auto-increments and wraps.
- Repeated START is supported.
- START/STOP are detected at any point in a transfer.
- The bus is sampled at system clock rate through synchronisers; there is no internal SCL-rate divider.
- Sits on the board-side I2C bus. It notifies the local design of every register write.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_line_sync.sv | 36 +++
 rtl/i2c_slave_regfile.sv | 151 +++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM states and bus constants for the I2C target blocks
package i2c_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK, WAIT_STOP
  } state_t;
  localparam int   RW_BIT = 0;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SCL/SDA synchronisers with SCL edge and START/STOP detection
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] r_scl, r_sda;
  logic r_scl_p, r_sda_p;
  logic w_scl_s;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_scl   <= '1;
      r_sda   <= '1;
      r_scl_p <= 1'b1;
      r_sda_p <= 1'b1;
    end else begin
      r_scl   <= {r_scl[SYNC_STAGES-2:0], scl_in};
      r_sda   <= {r_sda[SYNC_STAGES-2:0], sda_in};
      r_scl_p <= w_scl_s;
      r_sda_p <= sda_s;
    end
  assign w_scl_s   = r_scl[SYNC_STAGES-1];
  assign sda_s     = r_sda[SYNC_STAGES-1];
  assign scl_rise  = w_scl_s & ~r_scl_p;
  assign scl_fall  = ~w_scl_s & r_scl_p;
  assign start_det = r_sda_p & ~sda_s & w_scl_s & r_scl_p;
  assign stop_det  = ~r_sda_p & sda_s & w_scl_s;
endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with byte register file, auto-incrementing pointer and burst access
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         MEM_DEPTH   = 128,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             busy,
  output logic             done,
  output logic             nack_rx,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data
);
  state_t r_state, w_state;
  logic [3:0] r_bitcnt, w_bitcnt;
  logic [7:0] r_sh, w_sh, w_rd;
  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic [7:0] r_mem [MEM_DEPTH];
  logic w_rise, w_fall, w_sda, w_start, w_stop;
  logic w_oe, w_busy, w_done, w_nack, w_we, w_full, w_match, w_rx;
  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .scl_rise(w_rise), .scl_fall(w_fall), .sda_s(w_sda),
    .start_det(w_start), .stop_det(w_stop)
  );
  assign w_rd    = r_mem[r_ptr];
  assign w_full  = r_bitcnt == 4'd8;
  assign w_match = r_sh[7:1] == SLAVE_ADDR;
  assign w_rx    = r_state inside {ADDR, PTR, WDATA};
  // START/STOP take priority; otherwise receive on SCL rise, drive/advance on SCL fall
  always_comb begin
    w_state  = r_state;
    w_bitcnt = r_bitcnt;
    w_sh     = r_sh;
    w_ptr    = r_ptr;
    w_oe     = sda_oe;
    w_busy   = busy;
    w_done   = 1'b0;
    w_nack   = 1'b0;
    w_we     = 1'b0;
    if (w_start) begin
      w_state  = ADDR;
      w_bitcnt = '0;
      w_oe     = 1'b0;
      w_busy   = 1'b0;
    end else if (w_stop) begin
      w_state = IDLE;
      w_oe    = 1'b0;
      w_busy  = 1'b0;
      w_done  = busy;
    end else if (w_rx && w_rise && !w_full) begin
      w_sh     = {r_sh[6:0], w_sda};
      w_bitcnt = r_bitcnt + 4'd1;
    end else if (w_fall) begin
      case (r_state)
        ADDR: if (w_full) begin
          w_bitcnt = '0;
          w_oe     = w_match;
          w_state  = w_match ? ADDR_ACK : WAIT_STOP;
        end
        PTR: if (w_full) begin
          w_bitcnt = '0;
          w_ptr    = r_sh[PTR_W-1:0];
          w_oe     = 1'b1;
          w_state  = PTR_ACK;
        end
        WDATA: if (w_full) begin
          w_bitcnt = '0;
          w_we     = 1'b1;
          w_ptr    = r_ptr + 1'b1;
          w_oe     = 1'b1;
          w_state  = WDATA_ACK;
        end
        ADDR_ACK: begin
          w_busy   = 1'b1;
          w_bitcnt = {3'b0, r_sh[RW_BIT]};
          w_sh     = r_sh[RW_BIT] ? w_rd : r_sh;
          w_oe     = r_sh[RW_BIT] & ~w_rd[7];
          w_state  = r_sh[RW_BIT] ? RDATA : PTR;
        end
        PTR_ACK, WDATA_ACK: begin
          w_oe     = 1'b0;
          w_bitcnt = '0;
          w_state  = WDATA;
        end
        RDATA: if (w_full) begin
          w_oe     = 1'b0;
          w_ptr    = r_ptr + 1'b1;
          w_bitcnt = '0;
          w_state  = MACK;
        end else begin
          w_sh     = {r_sh[6:0], 1'b0};
          w_oe     = ~r_sh[6];
          w_bitcnt = r_bitcnt + 4'd1;
        end
        MACK: if (r_bitcnt != 4'd0) begin
          w_sh    = w_rd;
          w_oe    = ~w_rd[7];
          w_state = RDATA;
        end
        default: w_oe = 1'b0;
      endcase
    end else if (w_rise && r_state == MACK) begin
      w_nack   = w_sda == NACK;
      w_state  = w_sda == NACK ? WAIT_STOP : MACK;
      w_bitcnt = {3'b0, w_sda == ACK};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_sh     <= '0;
      r_ptr    <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_rx  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      r_state  <= w_state;
      r_bitcnt <= w_bitcnt;
      r_sh     <= w_sh;
      r_ptr    <= w_ptr;
      sda_oe   <= w_oe;
      busy     <= w_busy;
      done     <= w_done;
      nack_rx  <= w_nack;
      wr_valid <= w_we;
      if (w_we) begin
        wr_addr <= r_ptr;
        wr_data <= r_sh;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 8'(i);
    end else if (w_we) begin
      r_mem[r_ptr] <= r_sh;
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master with write/read scoreboards and vector table
module tb_i2c_slave_regfile;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic sda_oe, busy, done, nack_rx, wr_valid, sda_line;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  int total = 0, bad = 0, done_cnt = 0, nack_cnt = 0, wr_cnt = 0;
  logic oe_seen = 1'b0, busy_seen = 1'b0;
  logic [14:0] wq_exp [$];
  logic [7:0]  rq_exp [$];

  typedef struct {
    logic [7:0]  ptr;
    int          n;
    logic [23:0] d;
    logic [7:0]  nxt;
  } wvec_t;
  wvec_t vec [5];

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .MEM_DEPTH(128), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack_rx(nack_rx), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (nack_rx) nack_cnt <= nack_cnt + 1;
    if (sda_oe) oe_seen <= 1'b1;
    if (busy) busy_seen <= 1'b1;
    if (wr_valid && !rst) begin
      wr_cnt <= wr_cnt + 1;
      if (wq_exp.size() == 0) check("wr_unexpected", {17'b0, wr_addr, wr_data}, 32'h0);
      else check("wr_event", {17'b0, wr_addr, wr_data}, {17'b0, wq_exp.pop_front()});
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic qd(); #60; endtask
  task automatic start_c();
    sda_m = 1'b1; qd(); scl = 1'b1; qd(); sda_m = 1'b0; qd(); scl = 1'b0; qd();
  endtask
  task automatic stop_c();
    sda_m = 1'b0; qd(); scl = 1'b1; qd(); sda_m = 1'b1; qd();
  endtask
  task automatic bit_out(input logic b);
    sda_m = b; qd(); scl = 1'b1; qd(); qd(); scl = 1'b0; qd();
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_m = 1'b1; qd(); scl = 1'b1; qd(); ack = sda_line; qd(); scl = 1'b0; qd();
  endtask
  task automatic recv_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      qd(); scl = 1'b1; qd(); b = {b[6:0], sda_line}; qd(); scl = 1'b0;
    end
    qd(); sda_m = mack; qd(); scl = 1'b1; qd(); qd(); scl = 1'b0; qd();
  endtask

  task automatic i2c_write(input logic [7:0] p, input int n, input logic [23:0] d);
    logic a;
    logic [7:0] b;
    start_c();
    send_byte(8'hA0, a); check("wr_addr_ack", a, 0);
    send_byte(p, a);     check("wr_ptr_ack", a, 0);
    for (int k = 0; k < n; k++) begin
      b = d[23-8*k -: 8];
      wq_exp.push_back({p[6:0] + 7'(k), b});
      send_byte(b, a); check("wr_data_ack", a, 0);
    end
    stop_c();
  endtask

  task automatic i2c_read(input logic setp, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] b;
    start_c();
    if (setp) begin
      send_byte(8'hA0, a); check("rd_waddr_ack", a, 0);
      send_byte(p, a);     check("rd_ptr_ack", a, 0);
      start_c();
    end
    send_byte(8'hA1, a); check("rd_addr_ack", a, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      if (rq_exp.size() == 0) check("rd_no_expect", 1, 0);
      else check("rd_byte", b, rq_exp.pop_front());
    end
    stop_c();
  endtask

  initial begin
    logic a;
    int d0, w0, n0;
    vec[0] = '{8'h10, 3, 24'h112233, 8'h13};
    vec[1] = '{8'hFF, 2, 24'hAABB00, 8'h01};
    vec[2] = '{8'h20, 0, 24'h000000, 8'h20};
    vec[3] = '{8'h45, 1, 24'h5A0000, 8'h46};
    vec[4] = '{8'h7E, 3, 24'hC1D2E3, 8'h01};
    #23;
    check("reset_outputs", {sda_oe, busy, done, nack_rx, wr_valid, wr_addr, wr_data}, 0);
    #20 rst = 1'b0;
    #20 check("post_reset_outputs", {sda_oe, busy, done, nack_rx, wr_valid, wr_addr, wr_data}, 0);

    n0 = nack_cnt;
    rq_exp.push_back(8'h7F); rq_exp.push_back(8'h00); rq_exp.push_back(8'h01);
    i2c_read(1'b1, 8'h7F, 3);
    check("wrap_nack_count", nack_cnt - n0, 1);
    rq_exp.push_back(8'h02);
    i2c_read(1'b0, 8'h00, 1);

    d0 = done_cnt; w0 = wr_cnt; oe_seen = 1'b0; busy_seen = 1'b0;
    start_c();
    send_byte(8'hA2, a); check("nomatch_ack", a, 1);
    send_byte(8'h00, a); check("nomatch_data_ack", a, 1);
    stop_c();
    check("nomatch_oe_seen", oe_seen, 0);
    check("nomatch_busy_seen", busy_seen, 0);
    check("nomatch_done", done_cnt - d0, 0);
    check("nomatch_wr", wr_cnt - w0, 0);

    w0 = wr_cnt;
    start_c();
    send_byte(8'hA0, a); check("abort_addr_ack", a, 0);
    send_byte(8'h05, a); check("abort_ptr_ack", a, 0);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    stop_c();
    check("abort_busy", busy, 0);
    check("abort_wr", wr_cnt - w0, 0);
    rq_exp.push_back(8'h05);
    i2c_read(1'b1, 8'h05, 1);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt; w0 = wr_cnt;
      i2c_write(vec[v].ptr, vec[v].n, vec[v].d);
      check("vec_done", done_cnt - d0, 1);
      check("vec_wr_count", wr_cnt - w0, vec[v].n);
      rq_exp.push_back(vec[v].nxt);
      i2c_read(1'b0, 8'h00, 1);
      if (vec[v].n > 0) begin
        for (int k = 0; k < vec[v].n; k++) rq_exp.push_back(vec[v].d[23-8*k -: 8]);
        i2c_read(1'b1, vec[v].ptr, vec[v].n);
      end
    end

    rq_exp.push_back(8'h11);
    i2c_read(1'b1, 8'h10, 1);
    start_c();
    send_byte(8'hA0, a); check("rst_waddr_ack", a, 0);
    send_byte(8'h10, a); check("rst_ptr_ack", a, 0);
    start_c();
    send_byte(8'hA1, a); check("rst_raddr_ack", a, 0);
    for (int i = 0; i < 20 && !sda_oe; i++) @(negedge clk);
    check("rst_oe_before", sda_oe, 1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", {sda_oe, busy, done, nack_rx, wr_valid, wr_addr, wr_data}, 0);
    scl = 1'b1; sda_m = 1'b1;
    #50 rst = 1'b0;
    #50;
    rq_exp.push_back(8'h00);
    i2c_read(1'b0, 8'h00, 1);
    rq_exp.push_back(8'h10); rq_exp.push_back(8'h11);
    i2c_read(1'b1, 8'h10, 2);

    check("wq_drained", wq_exp.size(), 0);
    check("rq_drained", rq_exp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
